// File: rtl/rr_arbiter8_enc_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter8_enc_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter8_enc.sv
// Eight-way round-robin arbiter with a registered one-hot grant, its binary
// index, hold-until-release semantics and an optional hold-limit timeout.
module rr_arbiter8_enc #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  rr_arbiter8_enc_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam bit              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       gnt_idx_q, gnt_idx_d;
  logic             timeout_q, timeout_d;

  logic [2:0] win_idx;
  logic [2:0] cand;
  logic       found;
  logic       owner_req;
  logic       limit_hit;
  logic       release_now;

  // Scan from ptr upwards (mod 8); the first requester seen wins.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && bus.req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    owner_req   = bus.req[gnt_idx_q];
    limit_hit   = HOLD_EN && (hold_cnt_q == HOLD_LAST);
    release_now = bus.done || !owner_req || limit_hit;

    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = 8'b1 << win_idx;
          gnt_idx_d  = win_idx;
          hold_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      default: begin
        if (release_now) begin
          gnt_d     = '0;
          gnt_idx_d = '0;
          ptr_d     = gnt_idx_q + 3'd1;
          state_d   = IDLE;
          // A pulse only when the limit alone forced the release.
          timeout_d = limit_hit && !bus.done && owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8_enc.sv
// Scoreboard bench for rr_arbiter8_enc (hold limit of 4 cycles): expected
// outputs are queued as each cycle is driven and popped after the edge.
module tb_rr_arbiter8_enc;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter8_enc_if bus ();

  rr_arbiter8_enc #(
    .MAX_HOLD(4),
    .CNT_W   (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [12:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Expected {gnt, gnt_idx, gnt_valid, timeout}: k>=0 grant of k, -1 idle, -2 idle with timeout.
  function automatic logic [12:0] exp_of(input int code);
    logic [7:0] g;
    if (code >= 0) begin
      g = 8'b1 << code;
      return {g, 3'(code), 1'b1, 1'b0};
    end
    if (code == -2) return 13'h0001;
    return 13'h0000;
  endfunction

  function automatic logic [12:0] observed();
    return {bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout};
  endfunction

  task automatic push_exp(input int code, input string tag);
    exp_t e;
    e.exp = exp_of(code);
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drive_cycle(input logic [7:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [12:0] obs;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(-1, $sformatf("reset_hold_%0d", i));
      drive_cycle(8'hFF, 1'b0);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL reset: scoreboard empty");
      end else begin
        e   = sb.pop_front();
        obs = observed();
        if (obs !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: got {gnt,idx,valid,to}=%h need %h", e.tag, obs, e.exp);
        end
      end
    end
    bus.req = 8'h00;
    #2 rst_n = 1'b1;
    push_exp(-1, "reset_release_idle");
    drive_cycle(8'h00, 1'b0);
    checks++;
    e   = sb.pop_front();
    obs = observed();
    if (obs !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: got {gnt,idx,valid,to}=%h need %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic test_single();
    logic [7:0] r_tab[6] = '{8'h10, 8'h10, 8'h00, 8'h21, 8'h21, 8'h00};
    logic       d_tab[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int         x_tab[6] = '{4, -1, -1, 5, -1, -1};
    exp_t e;
    logic [12:0] obs;
    for (int i = 0; i < 6; i++) begin
      push_exp(x_tab[i], $sformatf("single_c%0d", i));
      drive_cycle(r_tab[i], d_tab[i]);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL single: scoreboard empty");
      end else begin
        e   = sb.pop_front();
        obs = observed();
        if (obs !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: got {gnt,idx,valid,to}=%h need %h", e.tag, obs, e.exp);
        end
      end
    end
  endtask

  // Entered with ptr=6; ends after a 7->0 wrap with ptr=0.
  task automatic test_wrap();
    logic [7:0] r_tab[9] = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h80, 8'h80, 8'h00};
    int         x_tab[9] = '{0, -1, 1, -1, 0, -1, 7, -1, -1};
    exp_t e;
    logic [12:0] obs;
    for (int i = 0; i < 9; i++) begin
      push_exp(x_tab[i], $sformatf("wrap_c%0d", i));
      drive_cycle(r_tab[i], 1'b1);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL wrap: scoreboard empty");
      end else begin
        e   = sb.pop_front();
        obs = observed();
        if (obs !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: got {gnt,idx,valid,to}=%h need %h", e.tag, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    logic [12:0] obs;
    for (int i = 0; i < 19; i++) begin
      if (i == 18) push_exp(-1, "rotation_tail");
      else push_exp((i % 2 == 0) ? (i / 2) % 8 : -1, $sformatf("rotation_c%0d", i));
      drive_cycle((i == 18) ? 8'h00 : 8'hFF, 1'b1);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL rotation: scoreboard empty");
      end else begin
        e   = sb.pop_front();
        obs = observed();
        if (obs !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: got {gnt,idx,valid,to}=%h need %h", e.tag, obs, e.exp);
        end
      end
    end
  endtask

  // Pure limit release pulses timeout; limit coinciding with done does not.
  task automatic test_timeout();
    logic [7:0] r_tab[13] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04,
                              8'h04, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h00};
    logic       d_tab[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int         x_tab[13] = '{2, 2, 2, 2, -2, 2, -1, 2, 2, 2, 2, -1, -1};
    exp_t e;
    logic [12:0] obs;
    for (int i = 0; i < 13; i++) begin
      push_exp(x_tab[i], $sformatf("timeout_c%0d", i));
      drive_cycle(r_tab[i], d_tab[i]);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL timeout: scoreboard empty");
      end else begin
        e   = sb.pop_front();
        obs = observed();
        if (obs !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: got {gnt,idx,valid,to}=%h need %h", e.tag, obs, e.exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    exp_t e;
    logic [12:0] obs;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0, 1: begin
          push_exp(7, $sformatf("midrst_grant_c%0d", i));
          drive_cycle(8'h80, 1'b0);
        end
        2: begin
          push_exp(-1, "midrst_async_drop");
          #2 rst_n = 1'b0;
          #1;
        end
        3: begin
          push_exp(-1, "midrst_held");
          drive_cycle(8'h81, 1'b0);
        end
        4: begin
          #2 rst_n = 1'b1;
          push_exp(0, "midrst_regrant_0");
          drive_cycle(8'h81, 1'b0);
        end
        5: begin
          push_exp(-1, "midrst_release");
          drive_cycle(8'h81, 1'b1);
        end
        default: begin
          push_exp(-1, "midrst_idle");
          drive_cycle(8'h00, 1'b0);
        end
      endcase
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL reset_mid_grant: scoreboard empty");
      end else begin
        e   = sb.pop_front();
        obs = observed();
        if (obs !== e.exp) begin
          errors++;
          $display("[TB] FAIL %s: got {gnt,idx,valid,to}=%h need %h", e.tag, obs, e.exp);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req  = 8'h00;
    bus.done = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_rotation();
    test_timeout();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
